// File: rtl/write_req_pkg.sv
// Shared types for the WriteReq path: beat layout and field widths.
// Imported by the WriteReq interface, the sink and its storage.
package write_req_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_beat_t;

endpackage

// File: rtl/write_req_if.sv
// WriteReq beat bundle: one address/data beat per valid cycle.
// There is no back-pressure signal.
interface WriteReq;
  import write_req_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              valid;

  modport master (output addr, output data, output valid);
  modport slave  (input addr, input data, input valid);

endinterface

// File: rtl/write_req_fifo_mem.sv
// Beat storage for the sink FIFO: one write port, async head read.
// Contents are deliberately not reset.
module write_req_fifo_mem
  import write_req_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  wr_beat_t      wdata,
  input  logic [PW-1:0] raddr,
  output wr_beat_t      rdata
);

  wr_beat_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/write_req_sink.sv
// WriteReq consumer: buffers beats in a show-ahead FIFO and drains
// them into a stallable byte-wide memory port, counting drops.
module write_req_sink
  import write_req_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  WriteReq.slave                     req_in,
  input  logic                       flush,
  input  logic                       clr_ovf,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  wr_beat_t      beat;
  wr_beat_t      head;

  assign beat = '{addr: req_in.addr, data: req_in.data};

  assign full      = (level == LW'(DEPTH));
  assign mem_valid = (level != '0);
  assign pop       = mem_valid & mem_ready;

  // A flushed cycle swallows the incoming beat without counting it.
  assign push = req_in.valid & ~flush & (~full | pop);
  assign drop = req_in.valid & ~flush & full & ~pop;

  // Gate the head so an empty FIFO never exposes stale storage.
  assign mem_addr  = mem_valid ? head.addr : '0;
  assign mem_wdata = mem_valid ? head.data : '0;

  write_req_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (beat),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)
        drop_cnt <= DROP_W'(1);
      else if (!(&drop_cnt))
        drop_cnt <= drop_cnt + DROP_W'(1);
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_write_req_sink.sv
// Randomized and directed bench for write_req_sink with a
// queue-based reference model and a write-port scoreboard.
module tb_write_req_sink;
  import write_req_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 4;
  localparam int LW     = $clog2(DEPTH+1);
  localparam int SAT    = 2**DROP_W - 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              flush = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              mem_ready = 1'b0;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  WriteReq req ();

  write_req_sink #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_in    (req),
    .flush     (flush),
    .clr_ovf   (clr_ovf),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 CLK = ~CLK;

  // Beats the memory must still receive, oldest first.
  wr_beat_t expq [$];
  wr_beat_t e;
  int       checks = 0;
  int       failures = 0;
  logic     m_ovf = 1'b0;
  int       m_cnt = 0;
  logic     flush_prev = 1'b0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Entered at a falling edge: check state, drive, update model.
  task automatic cycle(input logic v, input logic [31:0] a,
                       input logic [7:0] d, input logic rdy,
                       input logic fl, input logic clr);
    int sz;
    bit pop_e, acc, drp;
    if (flush_prev) expq.delete();
    sz = expq.size();
    chk("level", 32'(level), 32'(sz));
    chk("mem_valid", 32'(mem_valid), 32'(sz != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    if (sz != 0) begin
      chk("head_addr", mem_addr, expq[0].addr);
      chk("head_data", 32'(mem_wdata), 32'(expq[0].data));
    end else begin
      chk("idle_addr", mem_addr, 32'h0);
    end
    req.valid = v;
    req.addr  = a;
    req.data  = d;
    mem_ready = rdy;
    flush     = fl;
    clr_ovf   = clr;
    pop_e = (sz != 0) && rdy;
    acc   = v && !fl && (sz < DEPTH || pop_e);
    drp   = v && !fl && (sz == DEPTH) && !pop_e;
    if (drp) begin
      m_ovf = 1'b1;
      if (clr) m_cnt = 1;
      else if (m_cnt < SAT) m_cnt = m_cnt + 1;
    end else if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    if (acc) expq.push_back('{addr: a, data: d});
    flush_prev = fl;
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 8'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    RST = 1'b0;
    req.valid = 1'b0;
    #1;
    chk("rst_valid", 32'(mem_valid), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_cnt", 32'(drop_cnt), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    expq.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
    flush_prev = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // Scoreboard: every completed memory write must match the model.
  initial begin
    forever begin
      @(negedge CLK);
      #4;
      if (RST && mem_valid && mem_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected: got addr %0h expected none",
                   mem_addr);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", 32'(mem_wdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    req.valid = 1'b0;
    req.addr  = '0;
    req.data  = '0;
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("init_level", 32'(level), 32'h0);
    chk("init_valid", 32'(mem_valid), 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    // single beat, one-cycle latency
    cycle(1'b1, 32'h0000_1000, 8'hA5, 1'b1, 1'b0, 1'b0);
    chk("t2_level", 32'(level), 32'h1);
    chk("t2_addr", mem_addr, 32'h0000_1000);
    chk("t2_data", 32'(mem_wdata), 32'hA5);
    idle(1, 1'b1);
    chk("t2_drained", 32'(level), 32'h0);

    // stall and overfill
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h100 + i, 8'(i + 1), 1'b0, 1'b0, 1'b0);
    chk("t3_level", 32'(level), 32'h8);
    chk("t3_ovf", 32'(overflow), 32'h1);
    chk("t3_cnt", 32'(drop_cnt), 32'h2);

    // full with simultaneous pop accepts the beat
    cycle(1'b1, 32'hBEEF, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("t4_level", 32'(level), 32'h8);
    chk("t4_cnt", 32'(drop_cnt), 32'h2);
    idle(10, 1'b1);

    // flush at level 5 with a beat present
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h200 + i, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("t5_pre", 32'(level), 32'h5);
    cycle(1'b1, 32'h2FF, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("t5_level", 32'(level), 32'h0);
    chk("t5_valid", 32'(mem_valid), 32'h0);
    chk("t5_cnt", 32'(drop_cnt), 32'h2);

    // saturation, then clear racing a drop
    for (int i = 0; i < 28; i++)
      cycle(1'b1, 32'h300 + i, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("t6_sat", 32'(drop_cnt), 32'hF);
    cycle(1'b1, 32'h3FF, 8'h11, 1'b0, 1'b0, 1'b1);
    chk("t6_ovf", 32'(overflow), 32'h1);
    chk("t6_cnt", 32'(drop_cnt), 32'h1);
    cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    chk("t6_clr", 32'(overflow), 32'h0);
    idle(10, 1'b1);

    // reset mid-traffic
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h400 + i, 8'(i), 1'b0, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 9) < 7, $urandom, 8'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 3);
    idle(DEPTH + 2, 1'b1);
    chk("final_level", 32'(level), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
